// File: rtl/arb_pkg.sv
// Shared constants, FSM state and registered-output bundle for the 8-way round-robin mux arbiter.
package arb_pkg;
  localparam int NUM_REQ      = 8;
  localparam int SEL_W        = 3;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic {IDLE, OWN} state_t;

  typedef struct packed {
    logic [NUM_REQ-1:0] grant;
    logic [SEL_W-1:0]   select;
    logic               busy;
    logic               timeout;
  } arb_out_t;
endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate req so ptr lands at bit 0, take lowest set bit, un-rotate.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               found
);
  logic [NUM_REQ-1:0] rot;
  logic [SEL_W-1:0]   off;

  always_comb begin
    rot = NUM_REQ'({req, req} >> ptr);
    off = '0;
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (rot[i]) off = SEL_W'(i);
    // 3-bit add wraps back into requester space
    winner = ptr + off;
    found  = |req;
  end
endmodule

// File: rtl/mux_arbiter.sv
// Round-robin owner arbiter driving a shared 8:1 mux select; hold-until-done with one idle bubble.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module mux_arbiter
  import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
  #(parameter int unsigned MAX_HOLD = MAX_HOLD_DEF)
`endif
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   select,
  output logic               busy,
  output logic               timeout
);
  state_t           state, state_nx;
  arb_out_t         q, q_nx;
  logic [SEL_W-1:0] ptr, ptr_nx, winner;
  logic             found, rel, force_rel;

  rr_pick u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .found  (found)
  );

  assign rel = (state == OWN) && (done || !req[q.select]);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  logic [CNT_W-1:0] cnt, cnt_nx;

  // A normal release at the limit wins, so timeout only fires when nothing else ended ownership.
  always_comb begin
    force_rel = (state == OWN) && !rel && (cnt == CNT_W'(MAX_HOLD - 1));
    cnt_nx    = cnt;
    if (state == IDLE)          cnt_nx = '0;
    else if (!rel && !force_rel) cnt_nx = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else       cnt <= cnt_nx;
`else
  assign force_rel = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    q_nx      = q;
    q_nx.timeout = 1'b0;
    ptr_nx    = ptr;
    case (state)
      IDLE: if (found) begin
        q_nx.grant  = NUM_REQ'(1) << winner;
        q_nx.select = winner;
        q_nx.busy   = 1'b1;
        state_nx    = OWN;
      end
      OWN: if (rel || force_rel) begin
        q_nx         = '0;
        q_nx.timeout = force_rel;
        ptr_nx       = q.select + SEL_W'(1);
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      q     <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      q     <= q_nx;
      ptr   <= ptr_nx;
    end

  assign grant   = q.grant;
  assign select  = q.select;
  assign busy    = q.busy;
  assign timeout = q.timeout;
endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: directed steps push expected outputs, a negedge monitor pops and checks.
module tb_mux_arbiter;
  import arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset, done;
  logic [7:0] req, grant;
  logic [2:0] select;
  logic       busy, timeout;

  always #5 clk = ~clk;

`ifdef ARB_TIMEOUT_EN
  mux_arbiter #(.MAX_HOLD(4)) dut (
`else
  mux_arbiter dut (
`endif
    .clk(clk), .reset(reset), .req(req), .done(done),
    .grant(grant), .select(select), .busy(busy), .timeout(timeout)
  );

  arb_out_t expq[$];
  string    nmq[$];
  int       errors = 0;
  int       checks = 0;

  function automatic arb_out_t own(int i);
    arb_out_t e;
    e        = '0;
    e.grant  = 8'(1) << i;
    e.select = 3'(i);
    e.busy   = 1'b1;
    return e;
  endfunction

  function automatic arb_out_t idle_o();
    return '0;
  endfunction

  task automatic check(string nm, arb_out_t e);
    arb_out_t a;
    a = {grant, select, busy, timeout};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @%0t: got grant=%h sel=%0d busy=%b to=%b, want grant=%h sel=%0d busy=%b to=%b",
               nm, $time, a.grant, a.select, a.busy, a.timeout, e.grant, e.select, e.busy, e.timeout);
    end
  endtask

  // Inputs for one cycle; e is what the outputs must show after the next rising edge.
  task automatic step(string nm, logic [7:0] r, logic d, arb_out_t e);
    req  = r;
    done = d;
    expq.push_back(e);
    nmq.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  initial begin : monitor
    arb_out_t e;
    string    n;
    forever begin
      @(negedge clk);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        n = nmq.pop_front();
        check(n, e);
      end
    end
  end

  initial begin : stim
    arb_out_t to_o;
    to_o = '0;
    to_o.timeout = 1'b1;

    reset = 1'b1; req = '0; done = 1'b0;
    #12;
    check("reset_state", idle_o());
    @(negedge clk); #1;
    reset = 1'b0;

    // async reset while requester 5 owns
    step("own5", 8'h20, 1'b0, own(5));
    step("own5_hold", 8'h20, 1'b0, own(5));
    #2 reset = 1'b1;
    #1 check("async_reset_mid_own", idle_o());
    @(negedge clk); #1;
    reset = 1'b0;
    step("regrant5", 8'h20, 1'b0, own(5));
    step("rel5", 8'h20, 1'b1, idle_o());
    step("idle", 8'h00, 1'b0, idle_o());

    // lone requester 3, done on 3rd OWN cycle, re-grant after bubble
    step("own3", 8'h08, 1'b0, own(3));
    step("own3_c1", 8'h08, 1'b0, own(3));
    step("own3_c2", 8'h08, 1'b0, own(3));
    step("rel3", 8'h08, 1'b1, idle_o());
    step("regrant3", 8'h08, 1'b0, own(3));
    step("rel3b", 8'h08, 1'b1, idle_o());
    step("idle", 8'h00, 1'b0, idle_o());
    step("ptr4_pick", 8'h19, 1'b0, own(4));
    step("rel4", 8'h19, 1'b1, idle_o());
    step("idle", 8'h00, 1'b0, idle_o());

    // pointer wrap 6 -> 7 -> 0
    step("own6", 8'h40, 1'b0, own(6));
    step("rel6", 8'h40, 1'b1, idle_o());
    step("wrap_own7", 8'h81, 1'b0, own(7));
    step("rel7", 8'h81, 1'b1, idle_o());
    step("wrap_own0", 8'h81, 1'b0, own(0));
    step("rel0", 8'h81, 1'b1, idle_o());
    step("own7", 8'h80, 1'b0, own(7));
    step("rel7b", 8'h80, 1'b1, idle_o());

    // full round robin, done held high (also ignored while idle)
    for (int i = 0; i < 9; i++) begin
      step("rr_grant", 8'hFF, 1'b1, own(i % 8));
      step("rr_gap", 8'hFF, 1'b1, idle_o());
    end
    step("idle", 8'h00, 1'b0, idle_o());

    // withdrawal of owner 2 while 4 waits
    step("own2", 8'h14, 1'b0, own(2));
    step("own2_hold", 8'h14, 1'b0, own(2));
    step("withdraw2", 8'h10, 1'b0, idle_o());
    step("own4_after", 8'h10, 1'b0, own(4));
    step("rel4b", 8'h10, 1'b1, idle_o());
    step("idle", 8'h00, 1'b0, idle_o());

    // done and withdrawal together: ptr advances once
    step("own1", 8'h02, 1'b0, own(1));
    step("done_and_drop", 8'h00, 1'b1, idle_o());
    step("single_adv_own2", 8'h0C, 1'b0, own(2));
    step("rel2", 8'h0C, 1'b1, idle_o());
    step("idle", 8'h00, 1'b0, idle_o());

    // owner 1 never signals done
    step("to_own1", 8'h02, 1'b0, own(1));
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) step("to_hold", 8'h02, 1'b0, own(1));
    step("to_pulse", 8'h02, 1'b0, to_o);
    step("to_ptr2", 8'h06, 1'b0, own(2));
    step("rel2b", 8'h06, 1'b1, idle_o());
`else
    for (int i = 0; i < 100; i++) step("hold_unbounded", 8'h02, 1'b0, own(1));
    step("rel1", 8'h02, 1'b1, idle_o());
    step("after_ptr2", 8'h06, 1'b0, own(2));
    step("rel2b", 8'h06, 1'b1, idle_o());
`endif
    step("idle_end", 8'h00, 1'b0, idle_o());

    for (int k = 0; k < 5 && expq.size() != 0; k++) @(negedge clk);
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mux_arbiter.md
Name: mux_arbiter

Overview:
- Round-robin arbiter that shares one 8:1 select-driven datapath (e.g. a shared result or bus mux) between 8 requesters.
- Grants exclusive ownership to one requester at a time and drives the mux select.
- Holds the grant until the owner signals completion, then rotates priority.
- Sits between requesting units and the mux select input of the shared resource.

Parameters:
- NUM_REQ, 8, number of requesters; fixed at 8 so select width is 3.
- SEL_W, 3, width of the select output; equals log2(NUM_REQ).
- MAX_HOLD, 16, maximum cycles one owner may hold the grant. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  8  request per requester; bit i = requester i.
- done  input  1  the current owner releases the resource this cycle.
- grant  output  8  one-hot ownership; all zero when no owner.
- select  output  3  mux select = index of current owner; 0 when idle.
- busy  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse on forced release; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- All outputs are registered. Reset (async, active-high) sets:
  - state IDLE
  - grant = 0, select = 0, busy = 0, timeout = 0
  - priority pointer ptr = 0, hold counter = 0
- Reset asserted mid-ownership drops the grant immediately. No release bookkeeping occurs.
- FSM states: IDLE, OWN.
- IDLE:
  - If req != 0, the winner is the first set bit scanning ptr, ptr+1, … modulo 8.
  - Next edge: grant = one-hot(winner), select = winner, busy = 1, state OWN, hold counter = 0.
  - If req == 0, remain in IDLE with outputs at zero.
- OWN:
  - Grant and select are stable.
  - Other requests are ignored, including new or higher-index requests.
  - Release condition: done = 1, or req[owner] = 0 (owner withdrew).
  - On release, next edge: grant = 0, select = 0, busy = 0, ptr = (owner+1) mod 8 with wrap from 7 to 0, state IDLE.
- Latency:
  - Request in IDLE to grant: 1 cycle.
  - Release to the next grant: 2 cycles (one mandatory idle bubble) so the mux select settles before the new owner drives.
- done while IDLE: ignored.
- done and the owner's req drop in the same cycle: a single release; ptr advances once.
- Lone requester: re-granted after each bubble; ptr still rotates.
- Fairness: with all 8 requesting continuously and done each cycle, grants proceed in order 0,1,…,7,0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro:
  - The hold counter increments each OWN cycle.
  - When the counter reaches MAX_HOLD-1 without a release, the next edge forces the release.
  - A forced release behaves identically to a normal release: grant cleared, ptr advanced, IDLE.
  - timeout pulses high for that one cycle, coincident with grant going to 0.
  - done in the same cycle as the limit counts as a normal release; timeout stays 0.
- Without the macro: no counter exists, ownership is unbounded, and timeout is constant 0.

Decomposition:
- Package arb_pkg holds:
  - NUM_REQ = 8 and SEL_W = 3 constants
  - state typedef enum {IDLE, OWN}
  - default MAX_HOLD constant
- One combinational sub-module, rr_pick:
  - Inputs: req[7:0] and ptr[2:0].
  - Outputs: winner index[2:0] and a found flag.
  - Implemented as rotate, fixed-priority scan, then un-rotate.
- The FSM, pointer, counter and output registers live in mux_arbiter.

Test Plan:
- Reset behaviour: assert reset mid-OWN with owner 5 -> grant = 0, select = 0, busy = 0 immediately, without waiting for clk. After deassert, req = 8'h20 -> grant = 8'h20, select = 5 one cycle later.
- Single requester: req = 8'h08, done asserted on the 3rd OWN cycle -> grant = 8'h08 for 3 cycles, one idle cycle, then re-grant with ptr = 4.
- Full round-robin: req = 8'hFF held, done pulsed each OWN cycle -> select sequence 0,1,2,…,7,0 with a 1-cycle gap between each.
- Pointer wrap: ptr = 7 after owner 6, req = 8'h81 -> requester 7 is granted first, then 0.
- Withdrawal: owner 2 drops req[2] without done while req[4] is high -> release, then grant = 8'h10 two cycles after the drop.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD = 4): owner 1 never asserts done -> grant held exactly 4 cycles, timeout = 1 for one cycle, ptr = 2. Without the macro, the grant persists 100+ cycles and timeout stays 0.
